verificador_ganador: RTL and testbench

- Reads the 6x7 Connect Four board after each drop and reports whether a player has four in a line, or whether the game is a draw.
- Runs a sequential scan, one (row, column, direction) triple per cycle, over a board snapshot captured at start.
- Sits beside the drop logic. The game FSM pulses start after a drop reports done, then waits for done from this block.

---
 rtl/verificador_ganador_if.sv | 43 ++++
 rtl/verificador_ganador.sv | 216 +++++++++++++++++++++
 tb/tb_verificador_ganador.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/verificador_ganador_if.sv
// verificador_ganador_if
//   Bundles the request/result signals of the Connect Four win checker.
//   master: the game FSM (drives start and the board, reads results).
//   slave : verificador_ganador.
//   Signals:
//     start            request a scan (honoured only while the checker is idle)
//     tablero_in       board, [row][col] of 2-bit codes (00 empty, 01 P1, 10 P2, 11 invalid)
//     busy / done      scan in progress / one-cycle result-valid pulse
//     ganador, empate  winning player code, draw flag
//     win_row/col/dir  start cell and direction of the winning line
//     mascara_ganadora winning-cell bitmap (only with VERIFICADOR_MASCARA_EN)
interface verificador_ganador_if #(
    parameter int FILAS    = 6,
    parameter int COLUMNAS = 7
) ();
    localparam int RW = (FILAS > 1) ? $clog2(FILAS) : 1;
    localparam int CW = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1;

    logic                                  start;
    logic [FILAS-1:0][COLUMNAS-1:0][1:0]   tablero_in;
    logic                                  busy;
    logic                                  done;
    logic [1:0]                            ganador;
    logic                                  empate;
    logic [RW-1:0]                         win_row;
    logic [CW-1:0]                         win_col;
    logic [1:0]                            win_dir;
`ifdef VERIFICADOR_MASCARA_EN
    logic [FILAS-1:0][COLUMNAS-1:0]        mascara_ganadora;

    modport master (output start, tablero_in,
                    input  busy, done, ganador, empate, win_row, win_col, win_dir,
                           mascara_ganadora);
    modport slave  (input  start, tablero_in,
                    output busy, done, ganador, empate, win_row, win_col, win_dir,
                           mascara_ganadora);
`else
    modport master (output start, tablero_in,
                    input  busy, done, ganador, empate, win_row, win_col, win_dir);
    modport slave  (input  start, tablero_in,
                    output busy, done, ganador, empate, win_row, win_col, win_dir);
`endif
endinterface

// File: rtl/verificador_ganador.sv
// verificador_ganador
//   Connect Four win/draw checker. On start it snapshots the board and walks
//   every (row, col, dir) triple, one per clock, dir innermost, stopping at
//   the first line of EN_LINEA equal player cells. If nothing hits, the game
//   is a draw when the top row is full.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    verificador_ganador_if.slave (start/board in, results out)
//   Optional: define VERIFICADOR_MASCARA_EN to drive bus.mascara_ganadora,
//   a bitmap of the winning cells valid from the done pulse on.
module verificador_ganador #(
    parameter int FILAS    = 6,
    parameter int COLUMNAS = 7,
    parameter int EN_LINEA = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    verificador_ganador_if.slave bus
);
    localparam int RW = (FILAS > 1) ? $clog2(FILAS) : 1;
    localparam int CW = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, FIN} estado_t;
    typedef logic [FILAS-1:0][COLUMNAS-1:0][1:0] tablero_t;

    // Direction 0 right, 1 down, 2 down-right, 3 down-left (row 0 is the top).
    function automatic int delta_r(input logic [1:0] d);
        return (d == 2'd0) ? 0 : 1;
    endfunction

    function automatic int delta_c(input logic [1:0] d);
        case (d)
            2'd0:    return 1;
            2'd1:    return 0;
            2'd2:    return 1;
            default: return -1;
        endcase
    endfunction

    estado_t       state_q, state_d;
    tablero_t      snap_q, snap_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    ganador_q, ganador_d;
    logic          empate_q, empate_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [1:0]    win_dir_q, win_dir_d;
`ifdef VERIFICADOR_MASCARA_EN
    logic [FILAS-1:0][COLUMNAS-1:0] mask_q, mask_d;
`endif

    logic [1:0] celda;
    logic       dentro;
    logic       hit;
    logic       ultimo;
    logic       fila0_llena;

    // Evaluate the current triple. Line end is computed in int so that a
    // leftward run off column 0 shows up as negative instead of wrapping.
    always_comb begin
        int dr, dc, er, ec;
        celda  = snap_q[row_q][col_q];
        dr     = delta_r(dir_q);
        dc     = delta_c(dir_q);
        er     = int'(row_q) + dr * (EN_LINEA - 1);
        ec     = int'(col_q) + dc * (EN_LINEA - 1);
        dentro = (er < FILAS) && (ec >= 0) && (ec < COLUMNAS);
        // 11 is excluded here, so an all-invalid line never wins.
        hit    = dentro && ((celda == 2'b01) || (celda == 2'b10));
        if (dentro) begin
            for (int i = 1; i < EN_LINEA; i++) begin
                if (snap_q[RW'(int'(row_q) + i * dr)][CW'(int'(col_q) + i * dc)] != celda)
                    hit = 1'b0;
            end
        end
    end

    assign ultimo = (row_q == RW'(FILAS - 1)) && (col_q == CW'(COLUMNAS - 1)) && (dir_q == 2'd3);

    // Pieces stack from the bottom, so a full top row means a full board.
    always_comb begin
        fila0_llena = 1'b1;
        for (int c = 0; c < COLUMNAS; c++) begin
            if (snap_q[0][CW'(c)] == 2'b00) fila0_llena = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        row_d     = row_q;
        col_d     = col_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ganador_d = ganador_q;
        empate_d  = empate_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        win_dir_d = win_dir_q;
`ifdef VERIFICADOR_MASCARA_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d    = bus.tablero_in;
                    row_d     = '0;
                    col_d     = '0;
                    dir_d     = '0;
                    busy_d    = 1'b1;
                    ganador_d = 2'b00;
                    empate_d  = 1'b0;
                    win_row_d = '0;
                    win_col_d = '0;
                    win_dir_d = '0;
`ifdef VERIFICADOR_MASCARA_EN
                    mask_d    = '0;
`endif
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    ganador_d = celda;
                    win_row_d = row_q;
                    win_col_d = col_q;
                    win_dir_d = dir_q;
                    state_d   = FIN;
                end else if (ultimo) begin
                    empate_d  = fila0_llena;
                    state_d   = FIN;
                end else if (dir_q == 2'd3) begin
                    dir_d = 2'd0;
                    if (col_q == CW'(COLUMNAS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    dir_d = dir_q + 2'd1;
                end
            end
            FIN: begin
                // done/busy are registered, so they change on the edge that
                // leaves FIN and the result shows up one cycle after the hit.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef VERIFICADOR_MASCARA_EN
                mask_d  = '0;
                if (ganador_q != 2'b00) begin
                    for (int i = 0; i < EN_LINEA; i++)
                        mask_d[RW'(int'(win_row_q) + i * delta_r(win_dir_q))]
                              [CW'(int'(win_col_q) + i * delta_c(win_dir_q))] = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dir_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ganador_q <= 2'b00;
            empate_q  <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
            win_dir_q <= '0;
`ifdef VERIFICADOR_MASCARA_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ganador_q <= ganador_d;
            empate_q  <= empate_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            win_dir_q <= win_dir_d;
`ifdef VERIFICADOR_MASCARA_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ganador = ganador_q;
    assign bus.empate  = empate_q;
    assign bus.win_row = win_row_q;
    assign bus.win_col = win_col_q;
    assign bus.win_dir = win_dir_q;
`ifdef VERIFICADOR_MASCARA_EN
    assign bus.mascara_ganadora = mask_q;
`endif

endmodule

// File: tb/tb_verificador_ganador.sv
module tb_verificador_ganador;
    localparam int FILAS    = 6;
    localparam int COLUMNAS = 7;

    typedef logic [FILAS-1:0][COLUMNAS-1:0][1:0] board_t;
    typedef logic [FILAS-1:0][COLUMNAS-1:0]      mask_t;
    typedef struct {
        string      name;
        board_t     b;
        int         lat;
        logic [1:0] g;
        logic       e;
        int         r;
        int         c;
        int         d;
        mask_t      m;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int DR[4] = '{0, 1, 1, 1};
    int DC[4] = '{1, 0, 1, -1};

    verificador_ganador_if #(.FILAS(FILAS), .COLUMNAS(COLUMNAS)) bus ();

    verificador_ganador #(.FILAS(FILAS), .COLUMNAS(COLUMNAS), .EN_LINEA(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic board_t put_line(input board_t b, input int r, input int c, input int d,
                                        input logic [1:0] v);
        board_t t = b;
        for (int i = 0; i < 4; i++) t[r + i * DR[d]][c + i * DC[d]] = v;
        return t;
    endfunction

    // Reference: enumerate every line in scan order and take the first that
    // is four equal player pieces fully on the board.
    task automatic model(input board_t b, output int lat, output logic [1:0] g, output logic e,
                         output int wr, output int wc, output int wd, output mask_t m);
        int hit_n = -1;
        g = 2'b00; e = 1'b0; wr = 0; wc = 0; wd = 0; m = '0;
        for (int n = 0; n < FILAS * COLUMNAS * 4; n++) begin
            int r = n / (COLUMNAS * 4);
            int c = (n / 4) % COLUMNAS;
            int d = n % 4;
            int er = r + 3 * DR[d];
            int ec = c + 3 * DC[d];
            if (hit_n < 0 && er < FILAS && ec >= 0 && ec < COLUMNAS &&
                (b[r][c] == 2'b01 || b[r][c] == 2'b10)) begin
                bit ok = 1'b1;
                for (int i = 1; i < 4; i++)
                    if (b[r + i * DR[d]][c + i * DC[d]] != b[r][c]) ok = 1'b0;
                if (ok) begin
                    hit_n = n; g = b[r][c]; wr = r; wc = c; wd = d;
                    for (int i = 0; i < 4; i++) m[r + i * DR[d]][c + i * DC[d]] = 1'b1;
                end
            end
        end
        if (hit_n < 0) begin
            e = 1'b1;
            for (int c = 0; c < COLUMNAS; c++) if (b[0][c] == 2'b00) e = 1'b0;
            lat = 169;
        end else begin
            lat = hit_n + 2;
        end
    endtask

    // Start a scan at the next edge, measure edges until done, check results.
    task automatic run_case(input string nm, input board_t b, input int exp_lat,
                            input logic [1:0] eg, input logic ee, input int er, input int ec,
                            input int ed, input mask_t em, input bit disturb);
        int lat = -1;
        @(negedge clk);
        bus.tablero_in = b;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, " busy_on_accept"}, bus.busy, 1'b1);
        chk({nm, " done_low_on_accept"}, bus.done, 1'b0);
        for (int e = 1; e <= 300; e++) begin
            if (disturb && e == 20) begin
                bus.start      = 1'b1;
                bus.tablero_in = ~b;
            end
            if (disturb && e == 22) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                lat = e;
                break;
            end
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " ganador"}, bus.ganador, eg);
        chk({nm, " empate"}, bus.empate, ee);
        chk({nm, " win_row"}, bus.win_row, er[2:0]);
        chk({nm, " win_col"}, bus.win_col, ec[2:0]);
        chk({nm, " win_dir"}, bus.win_dir, ed[1:0]);
        chk({nm, " busy_at_done"}, bus.busy, 1'b0);
`ifdef VERIFICADOR_MASCARA_EN
        chk({nm, " mascara"}, bus.mascara_ganadora, em);
`endif
        @(posedge clk); #1;
        chk({nm, " done_pulse_one_cycle"}, bus.done, 1'b0);
        chk({nm, " ganador_held"}, bus.ganador, eg);
        bus.tablero_in = '0;
    endtask

    vec_t vecs[9];

    initial begin
        board_t b;
        mask_t  m;
        int     lat, wr, wc, wd;
        logic [1:0] g;
        logic   e;
        bit     seen;

        // Directed vectors with hand-derived expectations.
        vecs[0] = '{"empty", '0, 169, 2'b00, 1'b0, 0, 0, 0, '0};

        m = '0; for (int i = 0; i < 4; i++) m[5][i] = 1'b1;
        vecs[1] = '{"h_row5", put_line('0, 5, 0, 0, 2'b01), 142, 2'b01, 1'b0, 5, 0, 0, m};

        m = '0; for (int i = 2; i < 6; i++) m[i][6] = 1'b1;
        vecs[2] = '{"v_col6", put_line('0, 2, 6, 1, 2'b10), 83, 2'b10, 1'b0, 2, 6, 1, m};

        m = '0; m[2][3] = 1'b1; m[3][2] = 1'b1; m[4][1] = 1'b1; m[5][0] = 1'b1;
        b = '0; b[2][3] = 2'b01; b[3][2] = 2'b01; b[4][1] = 2'b01; b[5][0] = 2'b01;
        vecs[3] = '{"diag_dl", b, 73, 2'b01, 1'b0, 2, 3, 3, m};

        // Full board: colour flips every two columns and every row, so no
        // line of any direction has more than two equal cells.
        for (int r = 0; r < FILAS; r++)
            for (int c = 0; c < COLUMNAS; c++)
                b[r][c] = (((c / 2) + r) % 2 == 1) ? 2'b10 : 2'b01;
        vecs[4] = '{"draw", b, 169, 2'b00, 1'b1, 0, 0, 0, '0};

        // Four in a row only if the row wrapped into the next one.
        b = '0; b[0][4] = 2'b01; b[0][5] = 2'b01; b[0][6] = 2'b01; b[1][0] = 2'b01;
        vecs[5] = '{"no_wrap", b, 169, 2'b00, 1'b0, 0, 0, 0, '0};

        vecs[6] = '{"invalid_11", put_line('0, 2, 0, 1, 2'b11), 169, 2'b00, 1'b0, 0, 0, 0, '0};

        m = '0; for (int i = 3; i < 7; i++) m[0][i] = 1'b1;
        vecs[7] = '{"h_row0_edge", put_line('0, 0, 3, 0, 2'b10), 14, 2'b10, 1'b0, 0, 3, 0, m};

        m = '0; for (int i = 2; i < 6; i++) m[i][0] = 1'b1;
        vecs[8] = '{"v_col0", put_line('0, 2, 0, 1, 2'b01), 59, 2'b01, 1'b0, 2, 0, 1, m};

        bus.start      = 1'b0;
        bus.tablero_in = '0;
        reset          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset ganador", bus.ganador, 2'b00);
        chk("reset empate", bus.empate, 1'b0);
        chk("reset win", {bus.win_row, bus.win_col, bus.win_dir}, 8'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i])
            run_case(vecs[i].name, vecs[i].b, vecs[i].lat, vecs[i].g, vecs[i].e,
                     vecs[i].r, vecs[i].c, vecs[i].d, vecs[i].m, 1'b0);

        // Second start plus board changes mid-scan must not disturb the result.
        run_case("diag_disturbed", vecs[3].b, 73, 2'b01, 1'b0, 2, 3, 3, vecs[3].m, 1'b1);

        // Reset 50 edges into a scan: everything clears, no done ever appears.
        @(negedge clk);
        bus.tablero_in = '0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort done", bus.done, 1'b0);
        chk("abort ganador", bus.ganador, 2'b00);
        chk("abort empate", bus.empate, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort no_done", seen, 1'b0);
        run_case("after_abort", vecs[1].b, 142, 2'b01, 1'b0, 5, 0, 0, vecs[1].m, 1'b0);

        // Random boards against the reference model.
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < FILAS; r++)
                for (int c = 0; c < COLUMNAS; c++) begin
                    int x = $urandom_range(0, 9);
                    b[r][c] = (x < 4) ? 2'b00 : (x < 7) ? 2'b01 : (x < 9) ? 2'b10 : 2'b11;
                end
            model(b, lat, g, e, wr, wc, wd, m);
            run_case($sformatf("rand%0d", t), b, lat, g, e, wr, wc, wd, m, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
